// File: rtl/pu_mem_rd_sched_if.sv
// Requester/memory bus of the PU memory read scheduler.
// The scheduler takes the slave view; requesters and memory drive the master view.
interface pu_mem_rd_sched_if #(
    parameter int NUM_REQ    = 20,
    parameter int ADDR_NBITS = 16,
    parameter int DATA_NBITS = 32
);
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0][ADDR_NBITS-1:0] req_addr;
    logic                               mem_rd;
    logic [ADDR_NBITS-1:0]              mem_raddr;
    logic                               mem_ack;
    logic [DATA_NBITS-1:0]              mem_rdata;
    logic [NUM_REQ-1:0]                 rsp;
    logic [NUM_REQ-1:0][DATA_NBITS-1:0] rsp_data;
    logic                               err;

    modport master (
        output req, req_addr, mem_ack, mem_rdata,
        input  mem_rd, mem_raddr, rsp, rsp_data, err
    );

    modport slave (
        input  req, req_addr, mem_ack, mem_rdata,
        output mem_rd, mem_raddr, rsp, rsp_data, err
    );
endinterface

// File: rtl/pu_mem_rd_sched.sv
// Shares one in-order memory read port among NUM_REQ requesters: round-robin grant,
// bounded reads in flight, and a tag FIFO that routes each returning word to its owner.
module pu_mem_rd_sched #(
    parameter int NUM_REQ    = 20,
    parameter int ADDR_NBITS = 16,
    parameter int DATA_NBITS = 32,
    parameter int MAX_OUTST  = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    pu_mem_rd_sched_if.slave  bus_if
);
    localparam int LG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2
    } req_state_e;

    req_state_e                         state_q [NUM_REQ];
    req_state_e                         state_d [NUM_REQ];
    logic [NUM_REQ-1:0][ADDR_NBITS-1:0] addr_q, addr_d;
    logic [LG_W-1:0]                    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [MAX_OUTST-1:0][LG_W-1:0]     tag_q, tag_d;
    logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                               mem_rd_q, mem_rd_d;
    logic [ADDR_NBITS-1:0]              mem_raddr_q, mem_raddr_d;
    logic [NUM_REQ-1:0]                 rsp_q, rsp_d;
    logic [NUM_REQ-1:0][DATA_NBITS-1:0] rsp_data_q, rsp_data_d;
    logic                               err_q, err_d;

    logic                               gnt_s, pop_s;
    logic [LG_W-1:0]                    gnt_idx_s, pop_tag_s;
    logic [NUM_REQ-1:0]                 busy_s;

    function automatic logic [LG_W-1:0] rr_idx(input logic [LG_W-1:0] last, input int k);
        int s;
        s = int'(last) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return LG_W'(s);
    endfunction

    // Round-robin arbiter over waiting requesters, gated by the pre-pop in-flight count.
    always_comb begin
        gnt_s     = 1'b0;
        gnt_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy_s[i] = (state_q[i] != ST_IDLE);
        end
        if (cnt_q < CNT_MAX) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!gnt_s && (state_q[rr_idx(last_grant_q, k)] == ST_WAIT)) begin
                    gnt_s     = 1'b1;
                    gnt_idx_s = rr_idx(last_grant_q, k);
                end else begin
                    gnt_s     = gnt_s;
                end
            end
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Next-state: requester states, tag FIFO, in-flight count and registered outputs.
    always_comb begin
        pop_s        = bus_if.mem_ack && (cnt_q != '0);
        pop_tag_s    = tag_q[rd_ptr_q];
        state_d      = state_q;
        addr_d       = addr_q;
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_rd_d     = gnt_s;
        mem_raddr_d  = '0;
        rsp_d        = '0;
        rsp_data_d   = '0;
        // A request to a busy requester or an ack with nothing in flight is a protocol error.
        err_d        = err_q | (|(bus_if.req & busy_s)) | (bus_if.mem_ack & ~pop_s);

        for (int i = 0; i < NUM_REQ; i++) begin
            if (pop_s && (pop_tag_s == LG_W'(i))) begin
                state_d[i] = ST_IDLE;
            end else if (gnt_s && (gnt_idx_s == LG_W'(i))) begin
                state_d[i] = ST_ISSUED;
            end else if (bus_if.req[i] && (state_q[i] == ST_IDLE)) begin
                state_d[i] = ST_WAIT;
                addr_d[i]  = bus_if.req_addr[i];
            end else begin
                state_d[i] = state_q[i];
            end
        end

        if (gnt_s) begin
            mem_raddr_d      = addr_q[gnt_idx_s];
            last_grant_d     = gnt_idx_s;
            tag_d[wr_ptr_q]  = gnt_idx_s;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            mem_raddr_d      = '0;
        end

        if (pop_s) begin
            rd_ptr_d              = rd_ptr_q + PTR_W'(1'b1);
            rsp_d[pop_tag_s]      = 1'b1;
            rsp_data_d[pop_tag_s] = bus_if.mem_rdata;
        end else begin
            rd_ptr_d              = rd_ptr_q;
        end

        case ({gnt_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State register with synchronous reset; requester 0 has first priority afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= '{default: ST_IDLE};
            addr_q       <= '0;
            last_grant_q <= LG_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_rd_q     <= 1'b0;
            mem_raddr_q  <= '0;
            rsp_q        <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_rd_q     <= mem_rd_d;
            mem_raddr_q  <= mem_raddr_d;
            rsp_q        <= rsp_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
        end
    end

    assign bus_if.mem_rd    = mem_rd_q;
    assign bus_if.mem_raddr = mem_raddr_q;
    assign bus_if.rsp       = rsp_q;
    assign bus_if.rsp_data  = rsp_data_q;
    assign bus_if.err       = err_q;
endmodule

// File: tb/tb_pu_mem_rd_sched.sv
// Self-checking bench for pu_mem_rd_sched: directed scenarios plus random traffic,
// compared every cycle against a queue-based transaction model.
module tb_pu_mem_rd_sched;
    localparam int NUM_REQ    = 20;
    localparam int ADDR_NBITS = 16;
    localparam int DATA_NBITS = 32;
    localparam int MAX_OUTST  = 4;
    localparam int CW         = 1024;

    logic clk_i;
    logic rst_i;

    pu_mem_rd_sched_if #(.NUM_REQ(NUM_REQ), .ADDR_NBITS(ADDR_NBITS), .DATA_NBITS(DATA_NBITS)) bus ();

    pu_mem_rd_sched #(
        .NUM_REQ(NUM_REQ), .ADDR_NBITS(ADDR_NBITS), .DATA_NBITS(DATA_NBITS), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus_if (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks;
    int n_fail;
    int cyc;

    // memory responder
    int   mem_q[$];
    int   last_due;
    int   lat_min, lat_max;
    bit   fixed_en;
    logic [DATA_NBITS-1:0] fixed_val;
    int   rds_seen, acks_driven, max_out, rds_before_ack;
    logic [NUM_REQ-1:0] rsp_seen;

    // reference model
    bit                    m_wait [NUM_REQ];
    logic [ADDR_NBITS-1:0] m_addr [NUM_REQ];
    int                    m_fly[$];
    int                    m_last;
    logic                  m_err;

    logic                               exp_mem_rd;
    logic [ADDR_NBITS-1:0]              exp_raddr;
    logic [NUM_REQ-1:0]                 exp_rsp;
    logic [NUM_REQ-1:0][DATA_NBITS-1:0] exp_rsp_data;
    logic                               exp_err;

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit in_flight(input int id);
        foreach (m_fly[k]) if (m_fly[k] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_idle();
        if (m_fly.size() != 0) return 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (m_wait[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Predict the registered outputs of the next cycle from the inputs of this one.
    task automatic model_step();
        int g;
        int p;
        logic [NUM_REQ-1:0] accept;
        exp_mem_rd   = 1'b0;
        exp_raddr    = '0;
        exp_rsp      = '0;
        exp_rsp_data = '0;
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) m_wait[i] = 1'b0;
            m_fly.delete();
            m_last  = NUM_REQ - 1;
            m_err   = 1'b0;
            exp_err = 1'b0;
            return;
        end
        g = -1;
        if (m_fly.size() < MAX_OUTST) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int id;
                id = (m_last + k) % NUM_REQ;
                if (g < 0 && m_wait[id]) g = id;
            end
        end
        p = -1;
        if (bus.mem_ack) begin
            if (m_fly.size() > 0) p = m_fly[0];
            else m_err = 1'b1;
        end
        accept = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i]) begin
                if (!m_wait[i] && !in_flight(i)) accept[i] = 1'b1;
                else m_err = 1'b1;
            end
        end
        if (p >= 0) begin
            void'(m_fly.pop_front());
            exp_rsp[p]      = 1'b1;
            exp_rsp_data[p] = bus.mem_rdata;
        end
        if (g >= 0) begin
            m_fly.push_back(g);
            m_wait[g]  = 1'b0;
            m_last     = g;
            exp_mem_rd = 1'b1;
            exp_raddr  = m_addr[g];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                m_wait[i] = 1'b1;
                m_addr[i] = bus.req_addr[i];
            end
        end
        exp_err = m_err;
    endtask

    // One clock: memory answers, model predicts, outputs are sampled 1 ns after the edge.
    task automatic tick();
        int due;
        if (!bus.mem_ack && mem_q.size() > 0 && mem_q[0] <= cyc) begin
            void'(mem_q.pop_front());
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = fixed_en ? fixed_val : DATA_NBITS'($urandom());
        end
        if (bus.mem_ack) begin
            if (acks_driven == 0) rds_before_ack = rds_seen;
            acks_driven++;
        end
        model_step();
        @(posedge clk_i);
        #1;
        cyc++;
        check_eq("mem_rd", CW'(bus.mem_rd), CW'(exp_mem_rd));
        if (exp_mem_rd) check_eq("mem_raddr", CW'(bus.mem_raddr), CW'(exp_raddr));
        check_eq("rsp", CW'(bus.rsp), CW'(exp_rsp));
        check_eq("rsp_data", CW'(bus.rsp_data), CW'(exp_rsp_data));
        check_eq("err", CW'(bus.err), CW'(exp_err));
        rsp_seen = rsp_seen | bus.rsp;
        if (bus.mem_rd) begin
            rds_seen++;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back(due);
        end
        if (rds_seen - acks_driven > max_out) max_out = rds_seen - acks_driven;
        bus.req       = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = DATA_NBITS'($urandom());
        rst_i         = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 300 && !(model_idle() && mem_q.size() == 0)) begin
            tick();
            n++;
        end
        check_eq("drain_bound", CW'(n < 300), CW'(1'b1));
    endtask

    task automatic do_reset();
        repeat (2) begin
            rst_i = 1'b1;
            tick();
        end
        rds_seen       = 0;
        acks_driven    = 0;
        max_out        = 0;
        rds_before_ack = -1;
        rsp_seen       = '0;
    endtask

    initial begin
        logic [NUM_REQ-1:0][DATA_NBITS-1:0] v;
        int n;
        n_checks = 0; n_fail = 0; cyc = 0;
        last_due = 0; lat_min = 1; lat_max = 1;
        fixed_en = 1'b0; fixed_val = '0;
        rst_i = 1'b1;
        bus.req = '0; bus.req_addr = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_wait[i] = 1'b0;
            m_addr[i] = '0;
        end
        m_last = NUM_REQ - 1; m_err = 1'b0;
        do_reset();
        check_eq("reset_rsp_data", CW'(bus.rsp_data), CW'(0));

        // single request, memory latency 2
        lat_min = 2; lat_max = 2; fixed_en = 1'b1; fixed_val = 32'hDEADBEEF;
        bus.req[3] = 1'b1; bus.req_addr[3] = 16'h0040;
        tick();
        tick();
        check_eq("single_mem_rd", CW'(bus.mem_rd), CW'(1'b1));
        check_eq("single_raddr", CW'(bus.mem_raddr), CW'(16'h0040));
        repeat (3) tick();
        v = '0; v[3] = 32'hDEADBEEF;
        check_eq("single_rsp", CW'(bus.rsp), CW'(20'h00008));
        check_eq("single_rsp_data", CW'(bus.rsp_data), CW'(v));
        fixed_en = 1'b0;
        drain();

        // round-robin order
        do_reset();
        lat_min = 3; lat_max = 6;
        bus.req[0] = 1'b1; bus.req_addr[0] = 16'h0100;
        bus.req[5] = 1'b1; bus.req_addr[5] = 16'h0105;
        bus.req[19] = 1'b1; bus.req_addr[19] = 16'h0113;
        tick();
        tick();
        check_eq("rr_first", CW'(bus.mem_raddr), CW'(16'h0100));
        tick();
        check_eq("rr_second", CW'(bus.mem_raddr), CW'(16'h0105));
        tick();
        check_eq("rr_third", CW'(bus.mem_raddr), CW'(16'h0113));
        check_eq("rr_third_rd", CW'(bus.mem_rd), CW'(1'b1));
        drain();
        bus.req[0] = 1'b1; bus.req_addr[0] = 16'h0200;
        bus.req[5] = 1'b1; bus.req_addr[5] = 16'h0205;
        tick();
        tick();
        check_eq("rr_wrap_first", CW'(bus.mem_raddr), CW'(16'h0200));
        drain();

        // backpressure with long memory latency
        do_reset();
        lat_min = 10; lat_max = 10;
        for (int i = 1; i <= 6; i++) begin
            bus.req[i] = 1'b1;
            bus.req_addr[i] = ADDR_NBITS'($urandom());
        end
        tick();
        n = 0;
        while (acks_driven == 0 && n < 40) begin
            tick();
            n++;
        end
        check_eq("bp_rd_before_ack", CW'(rds_before_ack), CW'(4));
        drain();
        check_eq("bp_max_out", CW'(max_out), CW'(4));
        check_eq("bp_total_rd", CW'(rds_seen), CW'(6));

        // repeated request while issued
        do_reset();
        lat_min = 8; lat_max = 8;
        bus.req[2] = 1'b1; bus.req_addr[2] = 16'h0022;
        tick();
        tick();
        bus.req[2] = 1'b1; bus.req_addr[2] = 16'h0099;
        tick();
        check_eq("dup_err", CW'(bus.err), CW'(1'b1));
        drain();
        check_eq("dup_single_rd", CW'(rds_seen), CW'(1));

        // unsolicited ack
        do_reset();
        bus.mem_ack = 1'b1;
        tick();
        check_eq("unsol_rsp", CW'(bus.rsp), CW'(0));
        check_eq("unsol_err", CW'(bus.err), CW'(1'b1));

        // reset while three reads are in flight
        do_reset();
        lat_min = 8; lat_max = 8;
        for (int i = 0; i < 3; i++) begin
            bus.req[i] = 1'b1;
            bus.req_addr[i] = ADDR_NBITS'(16'h0300 + i);
        end
        tick();
        n = 0;
        while (rds_seen < 3 && n < 10) begin
            tick();
            n++;
        end
        check_eq("mid_three_rd", CW'(rds_seen), CW'(3));
        rst_i = 1'b1;
        tick();
        check_eq("mid_rst_mem_rd", CW'(bus.mem_rd), CW'(1'b0));
        check_eq("mid_rst_rsp", CW'(bus.rsp), CW'(0));
        check_eq("mid_rst_err", CW'(bus.err), CW'(1'b0));
        rsp_seen = '0;
        drain();
        check_eq("mid_late_rsp", CW'(rsp_seen), CW'(0));
        check_eq("mid_late_err", CW'(bus.err), CW'(1'b1));
        rsp_seen = '0;
        bus.req[1] = 1'b1; bus.req_addr[1] = 16'h0777;
        tick();
        drain();
        check_eq("mid_new_rsp", CW'(rsp_seen), CW'(20'h00002));

        // random traffic
        do_reset();
        lat_min = 1; lat_max = 6;
        repeat (600) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(15, 0) == 0) begin
                    if ((!m_wait[i] && !in_flight(i)) || $urandom_range(63, 0) == 0) begin
                        bus.req[i]      = 1'b1;
                        bus.req_addr[i] = ADDR_NBITS'($urandom());
                    end
                end
            end
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pu_mem_rd_sched.md
PU_MEM_RD_SCHED -- requirements
Module: pu_mem_rd_sched

Interface
REQ-001 Parameter NUM_REQ, default 20: number of requesters (PUs) sharing one memory read port.
REQ-002 Parameter ADDR_NBITS, default 16: memory read address width.
REQ-003 Parameter DATA_NBITS, default 32: memory read data width.
REQ-004 Parameter MAX_OUTST, default 4: maximum reads in flight on the memory port; power of two, at least 2.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 `RESET_SIG  in  1  reset, synchronous, active-high.
REQ-007 req  in  NUM_REQ  per-requester read request, one-cycle pulse.
REQ-008 req_addr  in  ADDR_NBITS x NUM_REQ  per-requester read address, valid with req.
REQ-009 mem_rd  out  1  memory read strobe, registered.
REQ-010 mem_raddr  out  ADDR_NBITS  memory read address, registered, valid with mem_rd.
REQ-011 mem_ack  in  1  memory read-data valid; returns in issue order, latency at least 1 cycle.
REQ-012 mem_rdata  in  DATA_NBITS  memory read data, valid with mem_ack.
REQ-013 rsp  out  NUM_REQ  per-requester response pulse, registered, one-hot or zero.
REQ-014 rsp_data  out  DATA_NBITS x NUM_REQ  response data; zero for every requester whose rsp is 0.
REQ-015 err  out  1  sticky protocol-error flag; cleared only by reset.

Function
REQ-016 Each requester has a 2-bit state: IDLE, WAIT (captured, not issued) or ISSUED (read in flight).
REQ-017 IDLE -> WAIT: on a cycle with req[i]=1; the block captures req_addr[i] into a per-requester address register.
REQ-018 req[i]=1 while requester i is in WAIT or ISSUED: the request is ignored, the state and address are unchanged, and err is set.
REQ-019 Arbitration: round-robin among requesters in WAIT; the search starts at last_grant+1 and wraps modulo NUM_REQ.
REQ-020 A grant occurs only when outst_cnt < MAX_OUTST.
REQ-021 On a grant to requester i in cycle t:
- mem_rd=1 and mem_raddr=addr[i] in cycle t+1;
- state i -> ISSUED;
- last_grant <= i;
- i is pushed into the tag FIFO (depth MAX_OUTST).
REQ-022 At most one grant is issued per cycle; mem_rd is 0 in every cycle that follows a cycle with no grant.
REQ-023 Minimum latency: req in cycle 0 -> WAIT from cycle 1 -> mem_rd in cycle 2.
REQ-024 outst_cnt (width log2(MAX_OUTST)+1):
- increments on a grant;
- decrements on a mem_ack that has a matching tag;
- is unchanged when both occur in the same cycle;
- never exceeds MAX_OUTST and never goes below 0.
REQ-025 On mem_ack in cycle k with the tag FIFO non-empty:
- the head tag j is popped;
- rsp[j]=1 and rsp_data[j]=mem_rdata in cycle k+1;
- state j -> IDLE at the end of cycle k.
REQ-026 A new req[j] in cycle k+1 (the same cycle as rsp[j]) is accepted normally.
REQ-027 mem_ack with the tag FIFO empty: no rsp is generated, outst_cnt stays at 0, and err is set.
REQ-028 Simultaneous grant and mem_ack in one cycle: the push and the pop both occur, and the FIFO remains order-correct.
- When the FIFO is full and a pop occurs, the grant is still blocked that cycle, because the cnt check uses the pre-pop value.
REQ-029 A requester is never granted twice before its response; this is guaranteed by the WAIT/ISSUED states.

Reset
REQ-030 While `RESET_SIG=1:
- all states go to IDLE;
- outst_cnt=0 and the tag FIFO is empty;
- last_grant=NUM_REQ-1, so requester 0 has first priority;
- mem_rd=0, mem_raddr=0, rsp=0, all rsp_data=0, err=0.
REQ-031 Reset asserted mid-operation discards all in-flight tags. Any mem_ack arriving after reset release without a matching tag sets err (REQ-027).
REQ-032 req is ignored in any cycle where `RESET_SIG=1.

Verification
REQ-033 Single request, memory latency 2: req[3] with addr 0x0040 in cycle 0 -> mem_rd with mem_raddr=0x0040 in cycle 2. mem_ack with rdata 0xDEADBEEF in cycle 4 -> rsp[3]=1 with rsp_data[3]=0xDEADBEEF in cycle 5; all other rsp_data are 0.
REQ-034 Round-robin order: after reset, req[0], req[5] and req[19] pulse together -> mem_rd in consecutive cycles 2, 3, 4 with addresses in order 0, 5, 19. A later req[0] and req[5] together -> 0 is granted first (last_grant=19).
REQ-035 Backpressure: MAX_OUTST=4, memory latency 10, requests from 6 PUs -> at most 4 mem_rd issued before the first mem_ack. Remaining grants resume one per ack, and outst_cnt never exceeds 4.
REQ-036 Protocol errors:
- req[2] repeated while requester 2 is ISSUED -> no second mem_rd and err=1;
- after reset, an unsolicited mem_ack -> no rsp and err=1.
REQ-037 Reset mid-flight: 3 reads outstanding, then `RESET_SIG pulses for 1 cycle -> all outputs are 0 the next cycle. The late mem_acks produce no rsp and set err. A new req[1] is then served normally.
